// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity encodings and the
// clocks-per-bit helper that the receiver uses as well.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT
  } txState_t;

  function automatic int baudCount(input int clkFreq, input int baudRate);
    return clkFreq / baudRate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous holding FIFO in front of the UART shifter. Pointers carry
// one extra wrap bit so the occupancy falls straight out of their difference.
module uart_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              dataIn,
  output logic [WIDTH-1:0]              dataOut,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;

  assign count   = wrPtr_q - rdPtr_q;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign dataOut = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (pop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= dataIn;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: buffers words in a small FIFO and shifts each out LSB-first
// as start / data / optional parity / one or two stop bits on a registered line.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int WIDTH      = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             dataInValid,
  output logic             dataInReady,
  output logic             uartTx,
  output logic             txBusy,
  output logic             txDone
);

  localparam int BAUD_COUNT = baudCount(CLK_FREQ, BAUD_RATE);
  localparam int BCW        = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
  localparam int BITW       = $clog2(WIDTH);
  localparam logic [BCW-1:0]  BAUD_LAST = BCW'(BAUD_COUNT - 1);
  localparam logic [BITW-1:0] BIT_LAST  = BITW'(WIDTH - 1);

  txState_t         state_q;
  logic [BCW-1:0]   baudCnt_q;
  logic [BITW-1:0]  bitCnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             parity_q;
  logic             stopCnt_q;
  logic             uartTx_q;
  logic             txDone_q;

  logic [WIDTH-1:0]               fifoHead;
  logic                           fifoFull;
  logic                           fifoEmpty;
  logic [$clog2(FIFO_DEPTH):0]    fifoCount;
  logic                           unusedFifoCount;

  logic baudWrap;
  logic lastStop;
  logic frameEnd;
  logic pop;
  logic headParity;

  assign baudWrap   = (baudCnt_q == BAUD_LAST);
  assign lastStop   = (STOP_BITS == 1) || stopCnt_q;
  assign frameEnd   = (state_q == STOP_BIT) && baudWrap && lastStop;
  // A new frame starts either from idle or directly off the end of the previous stop bit.
  assign pop        = !fifoEmpty && ((state_q == IDLE) || frameEnd);
  assign headParity = (PARITY == PARITY_ODD) ? ~^fifoHead : ^fifoHead;

  assign dataInReady     = !fifoFull;
  assign uartTx          = uartTx_q;
  assign txDone          = txDone_q;
  assign txBusy          = (state_q != IDLE);
  assign unusedFifoCount = ^fifoCount;

  uart_tx_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (dataInValid && dataInReady),
    .pop     (pop),
    .dataIn  (dataIn),
    .dataOut (fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      stopCnt_q <= 1'b0;
      uartTx_q  <= 1'b1;
      txDone_q  <= 1'b0;
    end else begin
      txDone_q <= 1'b0;
      if (state_q != IDLE) baudCnt_q <= baudWrap ? '0 : baudCnt_q + 1'b1;

      case (state_q)
        IDLE: ;
        START_BIT: if (baudWrap) begin
          state_q  <= DATA_BITS;
          bitCnt_q <= '0;
          uartTx_q <= shift_q[0];
          shift_q  <= shift_q >> 1;
        end
        DATA_BITS: if (baudWrap) begin
          if (bitCnt_q != BIT_LAST) begin
            bitCnt_q <= bitCnt_q + 1'b1;
            uartTx_q <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end else if (PARITY != PARITY_NONE) begin
            state_q  <= PARITY_BIT;
            uartTx_q <= parity_q;
          end else begin
            state_q   <= STOP_BIT;
            stopCnt_q <= 1'b0;
            uartTx_q  <= 1'b1;
          end
        end
        PARITY_BIT: if (baudWrap) begin
          state_q   <= STOP_BIT;
          stopCnt_q <= 1'b0;
          uartTx_q  <= 1'b1;
        end
        STOP_BIT: if (baudWrap) begin
          if (!lastStop) begin
            stopCnt_q <= 1'b1;
          end else begin
            txDone_q <= 1'b1;
            state_q  <= IDLE;
            uartTx_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Loading the next word overrides the idle fall-back at the end of a frame.
      if (pop) begin
        state_q   <= START_BIT;
        shift_q   <= fifoHead;
        parity_q  <= headParity;
        uartTx_q  <= 1'b0;
        baudCnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four instances (no parity, even, odd, two stop bits)
// are traced every cycle and compared against a frame-level model of the line.
module tb_uart_transmitter;

  localparam int BC    = 10;
  localparam int NI    = 4;
  localparam int TRACE = 8192;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [7:0]      dIn [NI];
  logic [NI-1:0]   dValid;
  wire  [NI-1:0]   txW, busyW, doneW, rdyW;

  int parCfg  [NI] = '{0, 1, 2, 0};
  int stopCfg [NI] = '{1, 1, 1, 2};

  logic trTx   [NI][TRACE];
  logic trBusy [NI][TRACE];
  logic trDone [NI][TRACE];
  logic trRdy  [NI][TRACE];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] wq [8];
  int accE [8];

  for (genvar g = 0; g < NI; g++) begin : gDut
    uart_transmitter #(
      .CLK_FREQ   (1_000_000),
      .BAUD_RATE  (100_000),
      .WIDTH      (8),
      .PARITY     ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
      .STOP_BITS  ((g == 3) ? 2 : 1),
      .FIFO_DEPTH (4)
    ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .dataIn      (dIn[g]),
      .dataInValid (dValid[g]),
      .dataInReady (rdyW[g]),
      .uartTx      (txW[g]),
      .txBusy      (busyW[g]),
      .txDone      (doneW[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Trace index n holds the outputs as they stand after rising edge n.
  always @(negedge clk) begin
    if (cyc < TRACE) begin
      for (int k = 0; k < NI; k++) begin
        trTx[k][cyc]   = txW[k];
        trBusy[k][cyc] = busyW[k];
        trDone[k][cyc] = doneW[k];
        trRdy[k][cyc]  = rdyW[k];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int frameLen(input int k);
    return (9 + ((parCfg[k] != 0) ? 1 : 0) + stopCfg[k]) * BC;
  endfunction

  // Line level t cycles after the first start bit of an n-word back-to-back stream.
  function automatic logic expLine(input int k, input int n, input int t);
    int L, f, b;
    logic [7:0] w;
    L = frameLen(k);
    if (t < 0 || t >= n * L) return 1'b1;
    f = t / L;
    b = (t % L) / BC;
    w = wq[f];
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (b == 9 && parCfg[k] != 0) return (parCfg[k] == 1) ? ^w : ~^w;
    return 1'b1;
  endfunction

  function automatic int countHigh(input int k, input int sel, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (sel == 0 && trTx[k][i] === 1'b1) c++;
      if (sel == 1 && trBusy[k][i] === 1'b1) c++;
      if (sel == 2 && trDone[k][i] === 1'b1) c++;
    end
    return c;
  endfunction

  task automatic pushWords(input int k, input int n, output bit ok);
    logic r;
    int waits;
    bit taken;
    ok = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < n; w++) begin
      dIn[k] = wq[w];
      dValid[k] = 1'b1;
      taken = 1'b0;
      waits = 0;
      while (!taken) begin
        @(negedge clk);
        r = rdyW[k];
        @(posedge clk); #1;
        if (r === 1'b1) begin
          taken = 1'b1;
          accE[w] = cyc;
        end else if (++waits > 400) begin
          $display("[TB] FAIL pushTimeout inst %0d word %0d: ready %b, want 1", k, w, r);
          checks++;
          errors++;
          dValid[k] = 1'b0;
          ok = 1'b0;
          return;
        end
      end
    end
    dValid[k] = 1'b0;
  endtask

  task automatic checkStream(input int k, input int n, input string name);
    int e, L, t;
    bit okTx = 1'b1, okBusy = 1'b1, okDone = 1'b1;
    logic expTx, expBusy, expDone;
    e = accE[0];
    L = frameLen(k);
    for (int i = e; i <= e + n * L + 3; i++) begin
      t = i - e - 1;
      expTx   = expLine(k, n, t);
      expBusy = (t >= 0 && t < n * L);
      expDone = (t > 0 && t <= n * L && (t % L) == 0);
      if (okTx && trTx[k][i] !== expTx) begin
        $display("[TB] FAIL %s uartTx at t=%0d: got %b, want %b", name, t, trTx[k][i], expTx);
        errors++;
        okTx = 1'b0;
      end
      if (okBusy && trBusy[k][i] !== expBusy) begin
        $display("[TB] FAIL %s txBusy at t=%0d: got %b, want %b", name, t, trBusy[k][i], expBusy);
        errors++;
        okBusy = 1'b0;
      end
      if (okDone && trDone[k][i] !== expDone) begin
        $display("[TB] FAIL %s txDone at t=%0d: got %b, want %b", name, t, trDone[k][i], expDone);
        errors++;
        okDone = 1'b0;
      end
    end
    checks += 3;
  endtask

  task automatic runStream(input int k, input int n, input string name, output bit ok);
    pushWords(k, n, ok);
    if (!ok) return;
    while (cyc < accE[0] + n * frameLen(k) + 6) @(posedge clk);
    checkStream(k, n, name);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({txW[k], busyW[k], doneW[k], rdyW[k]} !== 4'b1001) begin
        $display("[TB] FAIL reset inst %0d {tx,busy,done,ready}: got %b, want 1001",
                 k, {txW[k], busyW[k], doneW[k], rdyW[k]});
        errors++;
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_single_byte;
    bit ok;
    int e, n;
    logic [9:0] pat, obs;
    wq[0] = 8'hA5;
    runStream(0, 1, "single", ok);
    if (!ok) return;
    e = accE[0];
    pat = 10'b1101001010;
    for (int b = 0; b < 10; b++) obs[b] = trTx[0][e + 1 + b * BC + 5];
    checks++;
    if (obs !== pat) begin
      $display("[TB] FAIL singleBits: got %b, want %b", obs, pat);
      errors++;
    end
    n = countHigh(0, 1, e, e + 105);
    checks++;
    if (n != 100) begin
      $display("[TB] FAIL singleBusyLen: got %0d, want 100", n);
      errors++;
    end
    n = countHigh(0, 2, e, e + 105);
    checks++;
    if (n != 1) begin
      $display("[TB] FAIL singleDoneCount: got %0d, want 1", n);
      errors++;
    end
  endtask

  task automatic test_parity;
    bit ok;
    int e, n;
    for (int k = 1; k <= 2; k++) begin
      wq[0] = 8'h07;
      runStream(k, 1, (k == 1) ? "parityEven" : "parityOdd", ok);
      if (!ok) return;
      e = accE[0];
      checks++;
      if (trTx[k][e + 1 + 9 * BC + 5] !== ((k == 1) ? 1'b1 : 1'b0)) begin
        $display("[TB] FAIL parityBit inst %0d: got %b, want %b", k,
                 trTx[k][e + 1 + 9 * BC + 5], (k == 1) ? 1'b1 : 1'b0);
        errors++;
      end
      n = countHigh(k, 1, e, e + 115);
      checks++;
      if (n != 110) begin
        $display("[TB] FAIL parityFrameLen inst %0d: got %0d, want 110", k, n);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int e, n;
    wq[0] = 8'h55;
    wq[1] = 8'hAA;
    runStream(0, 2, "backToBack", ok);
    if (!ok) return;
    e = accE[0];
    checks++;
    if (accE[1] != e + 1) begin
      $display("[TB] FAIL b2bAccept: got edge %0d, want %0d", accE[1], e + 1);
      errors++;
    end
    n = countHigh(0, 1, e, e + 205);
    checks++;
    if (n != 200) begin
      $display("[TB] FAIL b2bBusyLen: got %0d, want 200", n);
      errors++;
    end
    checks++;
    if ({trDone[0][e + 101], trDone[0][e + 201], trTx[0][e + 101]} !== 3'b110) begin
      $display("[TB] FAIL b2bDoneAndStart: got %b, want 110",
               {trDone[0][e + 101], trDone[0][e + 201], trTx[0][e + 101]});
      errors++;
    end
  endtask

  task automatic test_fifo_full;
    bit ok;
    int e;
    for (int i = 0; i < 6; i++) wq[i] = 8'($urandom);
    runStream(0, 6, "fifoFull", ok);
    if (!ok) return;
    e = accE[0];
    checks++;
    if (accE[4] != e + 4) begin
      $display("[TB] FAIL fullFifthAccept: got edge %0d, want %0d", accE[4], e + 4);
      errors++;
    end
    checks++;
    if ({trRdy[0][accE[3]], trRdy[0][accE[4]]} !== 2'b10) begin
      $display("[TB] FAIL fullReady after 4th/5th: got %b, want 10",
               {trRdy[0][accE[3]], trRdy[0][accE[4]]});
      errors++;
    end
    checks++;
    if (accE[5] != e + 102) begin
      $display("[TB] FAIL fullSixthAccept: got edge %0d, want %0d", accE[5], e + 102);
      errors++;
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int e, r;
    bit okIdle = 1'b1;
    wq[0] = 8'h3C;
    wq[1] = 8'($urandom);
    wq[2] = 8'($urandom);
    pushWords(0, 3, ok);
    if (!ok) return;
    e = accE[0];
    while (cyc < e + 45) @(posedge clk);
    @(negedge clk); #2;
    resetn = 1'b0;
    r = cyc;
    #1;
    checks++;
    if ({txW[0], busyW[0], rdyW[0], doneW[0]} !== 4'b1010) begin
      $display("[TB] FAIL midReset {tx,busy,ready,done}: got %b, want 1010",
               {txW[0], busyW[0], rdyW[0], doneW[0]});
      errors++;
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    while (cyc < r + 305) @(posedge clk);
    for (int i = r + 1; i <= r + 300; i++) begin
      if (okIdle && {trTx[0][i], trBusy[0][i], trDone[0][i], trRdy[0][i]} !== 4'b1001) begin
        $display("[TB] FAIL postReset at cycle %0d {tx,busy,done,ready}: got %b, want 1001",
                 i - r, {trTx[0][i], trBusy[0][i], trDone[0][i], trRdy[0][i]});
        errors++;
        okIdle = 1'b0;
      end
    end
    checks++;
  endtask

  task automatic test_two_stop;
    bit ok;
    int e, n;
    wq[0] = 8'($urandom);
    runStream(3, 1, "twoStop", ok);
    if (!ok) return;
    e = accE[0];
    n = countHigh(3, 0, e + 91, e + 110);
    checks++;
    if (n != 20) begin
      $display("[TB] FAIL twoStopHigh: got %0d, want 20", n);
      errors++;
    end
    n = countHigh(3, 1, e, e + 115);
    checks++;
    if (n != 110) begin
      $display("[TB] FAIL twoStopFrameLen: got %0d, want 110", n);
      errors++;
    end
  endtask

  task automatic test_random;
    bit ok;
    int k, n;
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(0, NI - 1);
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) wq[i] = 8'($urandom);
      runStream(k, n, "random", ok);
      if (!ok) return;
    end
  endtask

  initial begin
    dValid = '0;
    for (int k = 0; k < NI; k++) dIn[k] = 8'h00;
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_two_stop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
